// File: rtl/position_stepper.sv
// One-hot position stepper: synchronized, debounced left/right buttons issue one load strobe per press.
// Optional POS_WRAP_EN: moves off either end wrap around instead of saturating.
module position_stepper #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [3:0] cur_pos,
    output logic [3:0] next_pos,
    output logic       load,
    output logic       busy,
    output logic [7:0] move_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        STEP     = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic [1:0] sync_l_q, sync_r_q;
    logic [3:0] pos_q, pos_d;
    logic       load_q, load_d;
    logic [7:0] mc_q, mc_d;

    logic       sl, sr;
    logic       cap, oth;
    logic       onehot;
    logic       at_edge;
    logic       step_ok;
    logic [3:0] step_pos;

    assign sl = sync_l_q[1];
    assign sr = sync_r_q[1];

    // dir: 0 = left (toward MSB), 1 = right (toward LSB)
    assign cap = dir_q ? sr : sl;
    assign oth = dir_q ? sl : sr;

    always_comb begin
        onehot = 1'b0;
        case (cur_pos)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: onehot = 1'b1;
            default:                            onehot = 1'b0;
        endcase
    end

    assign at_edge = dir_q ? (cur_pos == 4'b0001) : (cur_pos == 4'b1000);

    always_comb begin
        step_pos = 4'b1000;
        if (onehot) begin
            step_pos = dir_q ? {cur_pos[0], cur_pos[3:1]}
                             : {cur_pos[2:0], cur_pos[3]};
        end
    end

`ifdef POS_WRAP_EN
    assign step_ok = onehot || !at_edge;
`else
    assign step_ok = !onehot || !at_edge;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        load_d  = 1'b0;
        mc_d    = mc_q;
        unique case (state_q)
            IDLE: begin
                if (enable && (sl ^ sr)) begin
                    state_d = DEBOUNCE;
                    cnt_d   = 8'd0;
                    dir_d   = sr;
                end
            end
            DEBOUNCE: begin
                if (enable && cap && !oth) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = STEP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                state_d = HOLD;
                if (step_ok) begin
                    pos_d  = step_pos;
                    load_d = 1'b1;
                    mc_d   = mc_q + 8'd1;
                end
            end
            HOLD: begin
                if (!sl && !sr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            dir_q    <= 1'b0;
            sync_l_q <= 2'b00;
            sync_r_q <= 2'b00;
            pos_q    <= 4'b1000;
            load_q   <= 1'b0;
            mc_q     <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            sync_l_q <= {sync_l_q[0], btn_left};
            sync_r_q <= {sync_r_q[0], btn_right};
            pos_q    <= pos_d;
            load_q   <= load_d;
            mc_q     <= mc_d;
        end
    end

    assign next_pos   = pos_q;
    assign load       = load_q;
    assign busy       = (state_q != IDLE);
    assign move_count = mc_q;

endmodule

// File: tb/tb_position_stepper.sv
// Directed bench for position_stepper (DEBOUNCE_CYCLES = 4).
// Expectations follow POS_WRAP_EN when the bench is built with it defined.
module tb_position_stepper;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       btn_left;
    logic       btn_right;
    logic [3:0] cur_pos;
    logic [3:0] next_pos;
    logic       load;
    logic       busy;
    logic [7:0] move_count;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pre;

    position_stepper #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .cur_pos    (cur_pos),
        .next_pos   (next_pos),
        .load       (load),
        .busy       (busy),
        .move_count (move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic l, input logic r, input int hold);
        btn_left  = l;
        btn_right = r;
        tick(hold);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        tick(5);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        enable    = 1'b1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        cur_pos   = 4'b1000;
        tick(2);
        chk("rst_next_pos", next_pos, 4'b1000);
        chk("rst_load", load, 0);
        chk("rst_move", move_count, 0);
        chk("rst_busy", busy, 0);

        // clean right press from 1000, exact latency
        rst       = 1'b1;
        btn_right = 1'b1;
        pre       = pulses;
        tick(7);
        chk("lat_load_e7", load, 0);
        chk("lat_busy_e7", busy, 1);
        tick(1);
        chk("lat_load_e8", load, 1);
        chk("lat_next_pos", next_pos, 4'b0100);
        chk("lat_move", move_count, 1);
        tick(1);
        chk("lat_load_e9", load, 0);
        tick(11);
        chk("hold_busy", busy, 1);
        btn_right = 1'b0;
        tick(5);
        chk("hold_single", pulses - pre, 1);
        chk("hold_idle", busy, 0);

        // glitch on left: two cycles only
        pre      = pulses;
        btn_left = 1'b1;
        tick(2);
        btn_left = 1'b0;
        tick(1);
        chk("glitch_busy", busy, 1);
        tick(5);
        chk("glitch_idle", busy, 0);
        chk("glitch_nopulse", pulses - pre, 0);
        chk("glitch_move", move_count, 1);

        // mid-range moves
        cur_pos = 4'b0010;
        press(1'b1, 1'b0, 12);
        chk("mid_left", next_pos, 4'b0100);
        chk("mid_left_mv", move_count, 2);
        cur_pos = 4'b0100;
        press(1'b0, 1'b1, 12);
        chk("mid_right", next_pos, 4'b0010);
        chk("mid_right_mv", move_count, 3);

        // boundary left at 1000 after fresh reset
        do_reset();
        cur_pos = 4'b1000;
        pre     = pulses;
        press(1'b1, 1'b0, 12);
`ifdef POS_WRAP_EN
        chk("bnd_left_pos", next_pos, 4'b0001);
        chk("bnd_left_pl", pulses - pre, 1);
        chk("bnd_left_mv", move_count, 1);
`else
        chk("bnd_left_pos", next_pos, 4'b1000);
        chk("bnd_left_pl", pulses - pre, 0);
        chk("bnd_left_mv", move_count, 0);
`endif
        chk("bnd_left_idle", busy, 0);

        // boundary right at 0001
        do_reset();
        cur_pos = 4'b0001;
        pre     = pulses;
        press(1'b0, 1'b1, 12);
`ifdef POS_WRAP_EN
        chk("bnd_right_pl", pulses - pre, 1);
        chk("bnd_right_mv", move_count, 1);
`else
        chk("bnd_right_pl", pulses - pre, 0);
        chk("bnd_right_mv", move_count, 0);
`endif
        chk("bnd_right_pos", next_pos, 4'b1000);

        // both buttons together
        do_reset();
        cur_pos   = 4'b0010;
        pre       = pulses;
        btn_left  = 1'b1;
        btn_right = 1'b1;
        tick(6);
        chk("both_busy", busy, 0);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        tick(5);
        chk("both_nopulse", pulses - pre, 0);

        // non-one-hot recovery
        cur_pos = 4'b0110;
        pre     = pulses;
        press(1'b0, 1'b1, 12);
        chk("rec_pos", next_pos, 4'b1000);
        chk("rec_pulse", pulses - pre, 1);
        cur_pos = 4'b0000;
        press(1'b1, 1'b0, 12);
        chk("rec0_pos", next_pos, 4'b1000);
        chk("rec0_mv", move_count, 2);

        // reset during DEBOUNCE
        cur_pos  = 4'b0010;
        pre      = pulses;
        btn_left = 1'b1;
        tick(4);
        chk("rdb_busy", busy, 1);
        rst      = 1'b0;
        btn_left = 1'b0;
        tick(1);
        chk("rdb_busy0", busy, 0);
        chk("rdb_load", load, 0);
        chk("rdb_pos", next_pos, 4'b1000);
        chk("rdb_move", move_count, 0);
        rst = 1'b1;
        tick(6);
        chk("rdb_nopulse", pulses - pre, 0);

        // reset during STEP
        btn_left = 1'b1;
        tick(7);
        chk("rst_step_load", load, 0);
        chk("rst_step_busy", busy, 1);
        rst      = 1'b0;
        btn_left = 1'b0;
        tick(1);
        chk("rst_step_load0", load, 0);
        chk("rst_step_busy0", busy, 0);
        chk("rst_step_pos", next_pos, 4'b1000);
        rst = 1'b1;
        tick(6);
        chk("rst_step_nopulse", pulses - pre, 0);
        chk("rst_step_move", move_count, 0);

        // enable low blocks presses
        enable = 1'b0;
        press(1'b1, 1'b0, 12);
        chk("en0_nopulse", pulses - pre, 0);
        chk("en0_busy", busy, 0);
        enable = 1'b1;

        // 256 presses wrap the counter
        cur_pos = 4'b0010;
        for (int i = 0; i < 255; i++) press(1'b1, 1'b0, 10);
        chk("mv_255", move_count, 255);
        press(1'b1, 1'b0, 10);
        chk("mv_wrap", move_count, 0);
        chk("mv_pulses", pulses - pre, 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
